// File: rtl/countdown_pkg.sv
// Shared types, digit limits and load-value clamping for the mm:ss countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int             DIGIT_W      = 4;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

    // Clamp a {tens,ones} BCD pair: tens to tens_max, ones to 9.
    function automatic logic [2*DIGIT_W-1:0] bcd_clamp(input logic [2*DIGIT_W-1:0] val,
                                                       input logic [DIGIT_W-1:0]   tens_max);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = (val[7:4] > tens_max)  ? tens_max  : val[7:4];
        ones = (val[3:0] > DIGIT_MAX) ? DIGIT_MAX : val[3:0];
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown chain: loadable, decrements on dec_in, borrows at zero.
module bcd_digit_down
    import countdown_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_in,
    input  logic [DIGIT_W-1:0] wrap_val,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] digit_q;

    // Digit register: load has priority over decrement; zero wraps to wrap_val.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else if (load) begin
            digit_q <= load_val;
        end else if (dec_in) begin
            digit_q <= (digit_q == 4'd0) ? wrap_val : (digit_q - 4'd1);
        end else begin
            digit_q <= digit_q;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = dec_in && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown timer: FSM, tick prescaler and zero detect over a 4-digit borrow chain.
// Optional auto-reload on expiry is enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICKS_PER_DEC = 1,
    parameter int MAX_MIN_TENS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       load,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_DEC - 1);

    state_t      state_q, state_d;
    logic [7:0]  pre_q, pre_d;
    logic        expired_q, expired_d;
    logic        dec_s;
    logic        dig_load_s;
    logic [15:0] dig_val_s;
    logic [15:0] load_bcd_s;
    logic [15:0] count_s;
    logic        is_zero_s;
    logic        is_one_s;
    logic [2:0]  borrow_s;
    logic        top_borrow_unused_s;

    assign load_bcd_s = {bcd_clamp(load_mm, 4'(MAX_MIN_TENS)), bcd_clamp(load_ss, SEC_TENS_MAX)};
    assign count_s    = {mm, ss};
    assign is_zero_s  = (count_s == 16'h0000);
    assign is_one_s   = (count_s == 16'h0001);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] reload_q;

    // Reload value captured on every external load.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= 16'h0000;
        end else if (load) begin
            reload_q <= load_bcd_s;
        end else begin
            reload_q <= reload_q;
        end
    end
`endif

    // Next-state: load > start > pause > tick; start never consumes a tick.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        expired_d  = 1'b0;
        dec_s      = 1'b0;
        dig_load_s = 1'b0;
        dig_val_s  = load_bcd_s;
        if (load) begin
            state_d    = IDLE;
            pre_d      = 8'd0;
            dig_load_s = 1'b1;
        end else if (start) begin
            if ((state_q == IDLE) || (state_q == PAUSE)) begin
                if (is_zero_s) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (reload_q != 16'h0000) begin
                        state_d    = RUN;
                        dig_load_s = 1'b1;
                        dig_val_s  = reload_q;
                    end else begin
                        state_d   = DONE;
                        expired_d = 1'b1;
                    end
`else
                    state_d   = DONE;
                    expired_d = 1'b1;
`endif
                end else begin
                    state_d = RUN;
                end
            end else begin
                state_d = state_q;
            end
        end else if (pause) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end else begin
                state_d = state_q;
            end
        end else if (tick_en && (state_q == RUN)) begin
            if (pre_q >= PRE_LAST) begin
                pre_d = 8'd0;
                if (is_zero_s) begin
                    state_d   = DONE;
                    expired_d = 1'b1;
                end else if (is_one_s) begin
                    expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    dig_load_s = 1'b1;
                    dig_val_s  = reload_q;
`else
                    dec_s   = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    dec_s = 1'b1;
                end
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, prescaler and expiry pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= 8'd0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            expired_q <= expired_d;
        end
    end

    bcd_digit_down u_ss_ones (
        .clk(clk), .rst(rst), .dec_in(dec_s), .wrap_val(DIGIT_MAX),
        .load(dig_load_s), .load_val(dig_val_s[3:0]), .digit(ss[3:0]), .borrow_out(borrow_s[0])
    );
    bcd_digit_down u_ss_tens (
        .clk(clk), .rst(rst), .dec_in(borrow_s[0]), .wrap_val(SEC_TENS_MAX),
        .load(dig_load_s), .load_val(dig_val_s[7:4]), .digit(ss[7:4]), .borrow_out(borrow_s[1])
    );
    bcd_digit_down u_mm_ones (
        .clk(clk), .rst(rst), .dec_in(borrow_s[1]), .wrap_val(DIGIT_MAX),
        .load(dig_load_s), .load_val(dig_val_s[11:8]), .digit(mm[3:0]), .borrow_out(borrow_s[2])
    );
    // Minutes-tens never borrows: zero is caught before any decrement.
    bcd_digit_down u_mm_tens (
        .clk(clk), .rst(rst), .dec_in(borrow_s[2]), .wrap_val(4'(MAX_MIN_TENS)),
        .load(dig_load_s), .load_val(dig_val_s[15:12]), .digit(mm[7:4]), .borrow_out(top_borrow_unused_s)
    );

    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (1 and 3 ticks per count) share stimulus, checked against a seconds-count model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst, tick_en, load, start, pause;
    logic [7:0] load_mm, load_ss;
    logic [7:0] mm0, ss0, mm1, ss1;
    logic       run0, done0, exp0, run1, done1, exp1;
    logic [18:0] obs [2];

    int vectors = 0;
    int miscompares = 0;

    // Model: remaining time in seconds, mode 0 idle / 1 run / 2 paused / 3 done.
    int m_secs [2];
    int m_mode [2];
    int m_pre  [2];
    int m_exp  [2];
    int tpd    [2] = '{1, 3};

    always #5 clk = ~clk;

    countdown_timer #(.TICKS_PER_DEC(1), .MAX_MIN_TENS(5)) u_dut0 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .load(load), .load_mm(load_mm), .load_ss(load_ss),
        .start(start), .pause(pause), .mm(mm0), .ss(ss0), .running(run0), .done(done0), .expired(exp0)
    );
    countdown_timer #(.TICKS_PER_DEC(3), .MAX_MIN_TENS(5)) u_dut1 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .load(load), .load_mm(load_mm), .load_ss(load_ss),
        .start(start), .pause(pause), .mm(mm1), .ss(ss1), .running(run1), .done(done1), .expired(exp1)
    );

    assign obs[0] = {mm0, ss0, run0, done0, exp0};
    assign obs[1] = {mm1, ss1, run1, done1, exp1};

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [18:0] exp_vec(input int k);
        return {to_bcd(m_secs[k] / 60), to_bcd(m_secs[k] % 60),
                m_mode[k] == 1, m_mode[k] == 3, m_exp[k] != 0};
    endfunction

    task automatic model_update(input int k, input logic r, ld, st, ps, tk, input logic [7:0] lmm, lss);
        if (r) begin
            m_secs[k] = 0; m_mode[k] = 0; m_pre[k] = 0; m_exp[k] = 0;
        end else begin
            m_exp[k] = 0;
            if (ld) begin
                m_secs[k] = (lim(int'(lmm[7:4]), 5) * 10 + lim(int'(lmm[3:0]), 9)) * 60
                          + lim(int'(lss[7:4]), 5) * 10 + lim(int'(lss[3:0]), 9);
                m_mode[k] = 0;
                m_pre[k]  = 0;
            end else if (st) begin
                if (m_mode[k] == 0 || m_mode[k] == 2) begin
                    if (m_secs[k] == 0) begin m_mode[k] = 3; m_exp[k] = 1; end
                    else m_mode[k] = 1;
                end
            end else if (ps) begin
                if (m_mode[k] == 1) m_mode[k] = 2;
            end else if (tk && m_mode[k] == 1) begin
                m_pre[k]++;
                if (m_pre[k] == tpd[k]) begin
                    m_pre[k] = 0;
                    m_secs[k]--;
                    if (m_secs[k] == 0) begin m_mode[k] = 3; m_exp[k] = 1; end
                end
            end
        end
    endtask

    task automatic step(input logic r, ld, st, ps, tk, input logic [7:0] lmm, lss);
        rst = r; load = ld; start = st; pause = ps; tick_en = tk; load_mm = lmm; load_ss = lss;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k, r, ld, st, ps, tk, lmm, lss);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== 19'd0) begin
                miscompares++;
                $display("FAIL reset[%0d] got %h expected 0", k, obs[k]);
            end
        end
    endtask

    task automatic test_expire();
        logic [7:0] want [3] = '{8'h02, 8'h01, 8'h00};
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
            vectors++;
            if (ss0 !== want[t] || exp0 !== (t == 2)) begin
                miscompares++;
                $display("FAIL expire_tick%0d got ss=%h exp=%b expected ss=%h exp=%b", t, ss0, exp0, want[t], t == 2);
            end
        end
        vectors++;
        if (done0 !== 1'b1 || run0 !== 1'b0) begin
            miscompares++;
            $display("FAIL expire_flags got done=%b running=%b expected 1/0", done0, run0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL expire_after[%0d] got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_borrow();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        vectors++;
        if (mm0 !== 8'h09 || ss0 !== 8'h59) begin
            miscompares++;
            $display("FAIL borrow_10_00 got %h:%h expected 09:59", mm0, ss0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        vectors++;
        if (mm0 !== 8'h09 || ss0 !== 8'h58) begin
            miscompares++;
            $display("FAIL borrow_09_59 got %h:%h expected 09:58", mm0, ss0);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL borrow_model[%0d] got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_clamp();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7C, 8'hAF);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs[k] !== {8'h59, 8'h59, 3'b000}) begin
                miscompares++;
                $display("FAIL clamp[%0d] got %h expected 59:59 idle", k, obs[k]);
            end
        end
    endtask

    task automatic test_pause();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        vectors++;
        if (ss0 !== 8'h05 || run0 !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_hold got ss=%h running=%b expected 05/0", ss0, run0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        vectors++;
        if (ss0 !== 8'h05 || run0 !== 1'b1) begin
            miscompares++;
            $display("FAIL start_with_tick got ss=%h running=%b expected 05/1", ss0, run0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        vectors++;
        if (ss0 !== 8'h04) begin
            miscompares++;
            $display("FAIL resume_tick got ss=%h expected 04", ss0);
        end
    endtask

    task automatic test_zero_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        vectors++;
        if (obs[0] !== {16'h0000, 3'b011}) begin
            miscompares++;
            $display("FAIL zero_start got %h expected 0000 done+expired", obs[0]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        vectors++;
        if (obs[0] !== {16'h0000, 3'b010}) begin
            miscompares++;
            $display("FAIL zero_after got %h expected 0000 done only", obs[0]);
        end
    endtask

    task automatic test_prescale();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
            vectors++;
            if (ss1 !== ((t == 2) ? 8'h01 : 8'h02)) begin
                miscompares++;
                $display("FAIL prescale_tick%0d got ss=%h expected %h", t, ss1, (t == 2) ? 8'h01 : 8'h02);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        vectors++;
        if (obs[1] !== 19'd0) begin
            miscompares++;
            $display("FAIL prescale_rst got %h expected 0", obs[1]);
        end
    endtask

    task automatic test_random();
        logic r, ld, st, ps, tk;
        logic [7:0] lmm, lss;
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 99) < 6);
            st = ($urandom_range(0, 99) < 12);
            ps = ($urandom_range(0, 99) < 6);
            tk = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 3) != 0) begin
                lmm = 8'h00;
                lss = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            end else begin
                lmm = 8'($urandom);
                lss = 8'($urandom);
            end
            step(r, ld, st, ps, tk, lmm, lss);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (obs[k] !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random_c%0d[%0d] got %h expected %h", c, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick_en = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_mm = 8'h00; load_ss = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_secs[k] = 0; m_mode[k] = 0; m_pre[k] = 0; m_exp[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_expire();
        test_borrow();
        test_clamp();
        test_pause();
        test_zero_start();
        test_prescale();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
